// File: rtl/fb_write_arb_pkg.sv
// Shared types and constants for the frame-buffer write arbiter.
// The FIFO entry pairs a pixel with the buffer address computed when it was captured.
package fb_write_arb_pkg;

  localparam int IMG_W  = 240;
  localparam int IMG_H  = 320;
  localparam int ADDR_W = 17;
  localparam int PIX_W  = 7;

  typedef logic [1:0] bank_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  pixel;
  } fifo_entry_t;

  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [10:0] hcount,
                                                   input logic [9:0]  vcount,
                                                   input int          img_w);
    return ADDR_W'(vcount) * ADDR_W'(img_w) + ADDR_W'(hcount);
  endfunction

endpackage

// File: rtl/fb_arb_fifo.sv
// Per-requester pixel queue; a push into a full queue is only accepted when the
// same queue is popped that cycle, otherwise it is reported as a drop.
module fb_arb_fifo
  import fb_write_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  fifo_entry_t push_entry,
  input  logic        pop,
  output logic        empty,
  output logic        drop,
  output fifo_entry_t head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fifo_entry_t   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          take;
  logic          accept;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign take   = pop && !empty;
  assign accept = push && (!full || take);
  assign drop   = push && full && !take;
  assign head   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (take)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({accept, take})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/fb_write_arb.sv
// Round-robin arbiter merging NUM_REQ filter pixel streams onto one frame-buffer write port.
// Define FB_WRITE_ARB_STATS_EN to add per-requester saturating drop counters (drop_count_out).
module fb_write_arb
  import fb_write_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int IMG_W      = fb_write_arb_pkg::IMG_W,
  parameter int IMG_H      = fb_write_arb_pkg::IMG_H,
  parameter int PIX_W      = fb_write_arb_pkg::PIX_W
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic                           freeze_in,
  input  logic [NUM_REQ-1:0]             req_valid_in,
  input  logic [NUM_REQ-1:0][10:0]       req_hcount_in,
  input  logic [NUM_REQ-1:0][9:0]        req_vcount_in,
  input  logic [NUM_REQ-1:0][PIX_W-1:0]  req_pixel_in,
  output logic [NUM_REQ-1:0]             drop_out,
  output logic                           wr_en_out,
  output bank_t                          wr_bank_out,
  output logic [ADDR_W-1:0]              wr_addr_out,
  output logic [PIX_W-1:0]               wr_data_out
`ifdef FB_WRITE_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0]       drop_count_out
`endif
);

  localparam int          IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int          ENTRY_PIX_W = fb_write_arb_pkg::PIX_W;
  localparam logic [10:0] H_LIMIT     = 11'(IMG_W);
  localparam logic [9:0]  V_LIMIT     = 10'(IMG_H);

  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic [NUM_REQ-1:0] empty;
  logic [NUM_REQ-1:0] drop;
  fifo_entry_t        push_entry [NUM_REQ];
  fifo_entry_t        head       [NUM_REQ];

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_valid;

  // Out-of-range pixels never reach a FIFO, so they can neither write nor drop.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      push[i] = req_valid_in[i] && !freeze_in &&
                (req_hcount_in[i] < H_LIMIT) && (req_vcount_in[i] < V_LIMIT);
      push_entry[i].addr  = pixel_addr(req_hcount_in[i], req_vcount_in[i], IMG_W);
      push_entry[i].pixel = ENTRY_PIX_W'(req_pixel_in[i]);
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
    fb_arb_fifo #(
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk_in),
      .rst       (rst_in),
      .push      (push[g]),
      .push_entry(push_entry[g]),
      .pop       (pop[g]),
      .empty     (empty[g]),
      .drop      (drop[g]),
      .head      (head[g])
    );
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    pop         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_valid && !empty[(int'(rr_ptr) + k) % NUM_REQ]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
    if (grant_valid) pop[grant_idx] = 1'b1;
  end

  // Write port fields only update on a grant so they hold during idle cycles.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rr_ptr      <= '0;
      drop_out    <= '0;
      wr_en_out   <= 1'b0;
      wr_bank_out <= '0;
      wr_addr_out <= '0;
      wr_data_out <= '0;
    end else begin
      drop_out  <= drop;
      wr_en_out <= grant_valid;
      if (grant_valid) begin
        rr_ptr      <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        wr_bank_out <= bank_t'(grant_idx);
        wr_addr_out <= head[grant_idx].addr;
        wr_data_out <= PIX_W'(head[grant_idx].pixel);
      end
    end
  end

`ifdef FB_WRITE_ARB_STATS_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      drop_count_out <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (drop[i] && (drop_count_out[i] != 16'hFFFF)) begin
          drop_count_out[i] <= drop_count_out[i] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_fb_write_arb.sv
// Scoreboard bench for fb_write_arb: directed stimulus queues expected writes,
// a negedge monitor pops and compares each write and tallies drop pulses.
module tb_fb_write_arb;

  typedef struct packed {
    logic [1:0]  bank;
    logic [16:0] addr;
    logic [6:0]  data;
  } exp_t;

  logic              clk_in;
  logic              rst_in;
  logic              freeze_in;
  logic [3:0]        req_valid_in;
  logic [3:0][10:0]  req_hcount_in;
  logic [3:0][9:0]   req_vcount_in;
  logic [3:0][6:0]   req_pixel_in;
  logic [3:0]        drop_out;
  logic              wr_en_out;
  logic [1:0]        wr_bank_out;
  logic [16:0]       wr_addr_out;
  logic [6:0]        wr_data_out;
`ifdef FB_WRITE_ARB_STATS_EN
  logic [3:0][15:0]  drop_count_out;
`endif

  int   errors = 0;
  int   checks = 0;
  int   drop_seen [4];
  exp_t exp_q [$];

  fb_write_arb dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .freeze_in     (freeze_in),
    .req_valid_in  (req_valid_in),
    .req_hcount_in (req_hcount_in),
    .req_vcount_in (req_vcount_in),
    .req_pixel_in  (req_pixel_in),
    .drop_out      (drop_out),
    .wr_en_out     (wr_en_out),
    .wr_bank_out   (wr_bank_out),
    .wr_addr_out   (wr_addr_out),
    .wr_data_out   (wr_data_out)
`ifdef FB_WRITE_ARB_STATS_EN
    ,
    .drop_count_out(drop_count_out)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  function automatic void pushExpect(input int bank, input int addr, input int data);
    exp_t e;
    e.bank = 2'(bank);
    e.addr = 17'(addr);
    e.data = 7'(data);
    exp_q.push_back(e);
  endfunction

  task automatic applyStimulus(input logic [3:0] mask, input logic [3:0][10:0] h,
                               input logic [3:0][9:0] v, input logic [3:0][6:0] p);
    @(negedge clk_in);
    req_hcount_in = h;
    req_vcount_in = v;
    req_pixel_in  = p;
    req_valid_in  = mask;
  endtask

  task automatic releaseInputs();
    @(negedge clk_in);
    req_valid_in = '0;
  endtask

  task automatic resetDut();
    @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    checkOutput("rst_wr_en", 32'(wr_en_out), 0);
    checkOutput("rst_bank", 32'(wr_bank_out), 0);
    checkOutput("rst_addr", 32'(wr_addr_out), 0);
    checkOutput("rst_data", 32'(wr_data_out), 0);
    checkOutput("rst_drop", 32'(drop_out), 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    for (int i = 0; i < 4; i++) drop_seen[i] = 0;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    checkOutput("drain_pending", 32'(exp_q.size()), 0);
    exp_q.delete();
    repeat (3) @(negedge clk_in);
  endtask

  task automatic checkDrops(input int e0, input int e1, input int e2, input int e3);
    int expd [4];
    expd = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drop_pulses[%0d]", i), 32'(drop_seen[i]), 32'(expd[i]));
`ifdef FB_WRITE_ARB_STATS_EN
      checkOutput($sformatf("drop_count[%0d]", i), 32'(drop_count_out[i]), 32'(expd[i]));
`endif
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_in);
      if (!rst_in) begin
        for (int i = 0; i < 4; i++) if (drop_out[i]) drop_seen[i]++;
        if (wr_en_out) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_write", 32'(wr_en_out), 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("write", {6'd0, wr_bank_out, wr_addr_out, wr_data_out},
                        {6'd0, e.bank, e.addr, e.data});
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0][10:0] h;
    logic [3:0][9:0]  v;
    logic [3:0][6:0]  p;
    rst_in        = 1'b0;
    freeze_in     = 1'b0;
    req_valid_in  = '0;
    req_hcount_in = '0;
    req_vcount_in = '0;
    req_pixel_in  = '0;
    h = '0;
    v = '0;
    p = '0;

    $display("[TB] single pixel on requester 2");
    resetDut();
    pushExpect(2, 725, 7'h55);
    h[2] = 11'd5; v[2] = 10'd3; p[2] = 7'h55;
    applyStimulus(4'b0100, h, v, p);
    releaseInputs();
    checkOutput("latency_1cyc", 32'(wr_en_out), 0);
    @(negedge clk_in);
    checkOutput("latency_2cyc", 32'(wr_en_out), 1);
    waitDrain(10);
    checkOutput("hold_wr_en", 32'(wr_en_out), 0);
    checkOutput("hold_bank", 32'(wr_bank_out), 2);
    checkOutput("hold_addr", 32'(wr_addr_out), 725);
    checkOutput("hold_data", 32'(wr_data_out), 7'h55);
    checkDrops(0, 0, 0, 0);

    $display("[TB] all four requesters at once, then pointer check");
    resetDut();
    for (int i = 0; i < 4; i++) begin
      h[i] = 11'(10 + i); v[i] = 10'(i); p[i] = 7'(8'h20 + i);
      pushExpect(i, i * 240 + 10 + i, 8'h20 + i);
    end
    applyStimulus(4'b1111, h, v, p);
    releaseInputs();
    waitDrain(20);
    pushExpect(0, 100, 7'h11);
    pushExpect(3, 3 * 240 + 50, 7'h33);
    h[0] = 11'd100; v[0] = 10'd0; p[0] = 7'h11;
    h[3] = 11'd50;  v[3] = 10'd3; p[3] = 7'h33;
    applyStimulus(4'b1001, h, v, p);
    releaseInputs();
    waitDrain(20);
    checkDrops(0, 0, 0, 0);

    $display("[TB] sustained traffic on all requesters, FIFOs overflow");
    resetDut();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 4; i++) begin
        if (r < 5 || i < 3) begin
          int k;
          k = (r < 5) ? r : i + 5;
          pushExpect(i, i * 240 + k, i * 16 + k);
        end
      end
    end
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++) begin
        h[i] = 11'(k); v[i] = 10'(i); p[i] = 7'(i * 16 + k);
      end
      applyStimulus(4'b1111, h, v, p);
    end
    releaseInputs();
    waitDrain(60);
    checkDrops(2, 2, 2, 3);

    $display("[TB] image boundary");
    resetDut();
    h[0] = 11'd240; v[0] = 10'd0;   p[0] = 7'h01;
    h[1] = 11'd0;   v[1] = 10'd320; p[1] = 7'h02;
    h[2] = 11'd239; v[2] = 10'd319; p[2] = 7'h7F;
    pushExpect(2, 76799, 7'h7F);
    applyStimulus(4'b0111, h, v, p);
    releaseInputs();
    waitDrain(10);
    checkDrops(0, 0, 0, 0);

    $display("[TB] freeze with three entries queued");
    resetDut();
    for (int i = 0; i < 4; i++) begin
      h[i] = 11'(20 + i); v[i] = 10'(5); p[i] = 7'(8'h40 + i);
    end
    pushExpect(0, 5 * 240 + 20, 8'h40);
    pushExpect(1, 5 * 240 + 21, 8'h41);
    pushExpect(2, 5 * 240 + 22, 8'h42);
    applyStimulus(4'b0111, h, v, p);
    @(negedge clk_in);
    freeze_in    = 1'b1;
    req_valid_in = 4'b1111;
    repeat (3) @(negedge clk_in);
    req_valid_in = '0;
    @(negedge clk_in);
    freeze_in = 1'b0;
    waitDrain(10);
    pushExpect(3, 5 * 240 + 23, 8'h43);
    applyStimulus(4'b1000, h, v, p);
    releaseInputs();
    waitDrain(10);
    checkDrops(0, 0, 0, 0);

    $display("[TB] asynchronous reset mid-drain");
    resetDut();
    for (int i = 0; i < 4; i++) begin
      h[i] = 11'(30 + i); v[i] = 10'(7); p[i] = 7'(8'h60 + i);
    end
    pushExpect(0, 7 * 240 + 30, 8'h60);
    pushExpect(1, 7 * 240 + 31, 8'h61);
    applyStimulus(4'b1111, h, v, p);
    releaseInputs();
    @(negedge clk_in);
    @(negedge clk_in);
    #2;
    rst_in = 1'b1;
    #1;
    checkOutput("async_rst_wr_en", 32'(wr_en_out), 0);
    checkOutput("async_rst_bank", 32'(wr_bank_out), 0);
    checkOutput("async_rst_addr", 32'(wr_addr_out), 0);
    checkOutput("async_rst_data", 32'(wr_data_out), 0);
    @(negedge clk_in);
    #2;
    rst_in = 1'b0;
    repeat (6) @(negedge clk_in);
    checkOutput("post_rst_pending", 32'(exp_q.size()), 0);
    checkOutput("post_rst_addr", 32'(wr_addr_out), 0);
    h[1] = 11'd1; v[1] = 10'd1; p[1] = 7'h0A;
    h[3] = 11'd3; v[3] = 10'd3; p[3] = 7'h0C;
    pushExpect(1, 241, 7'h0A);
    pushExpect(3, 723, 7'h0C);
    applyStimulus(4'b1010, h, v, p);
    releaseInputs();
    waitDrain(10);
    checkDrops(0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
